// File: rtl/rename_regfile_pkg.sv
// Shared widths, tag encoding and CDB record type for the rename register file.
// Configuration macro: RF_CDB_BYPASS_EN (same-cycle CDB forwarding on read ports).
package rename_regfile_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int RF_NREG    = 32;
  localparam int RF_DATA_W  = 32;
  localparam int RF_TAG_W   = 4;
  localparam int RF_NUM_RD  = 2;
  localparam int RF_NUM_CDB = 2;
  localparam int RF_NAME_W  = clog2(RF_NREG);

  localparam logic [RF_TAG_W-1:0] TAG_FREE = '0;

  typedef struct packed {
    logic                 valid;
    logic [RF_NAME_W-1:0] name;
    logic [RF_TAG_W-1:0]  tag;
    logic [RF_DATA_W-1:0] data;
  } cdb_bus_t;

endpackage

// File: rtl/rename_regfile_if.sv
// Dispatch / CDB / read-port bundle between the dispatcher side and the register file.
// Configuration macro: RF_CDB_BYPASS_EN (affects rd_data/rd_tag timing only).
interface rename_regfile_if
  import rename_regfile_pkg::*;
#(
  parameter int NAME_W  = RF_NAME_W,
  parameter int DATA_W  = RF_DATA_W,
  parameter int TAG_W   = RF_TAG_W,
  parameter int NUM_RD  = RF_NUM_RD,
  parameter int NUM_CDB = RF_NUM_CDB
);
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*NAME_W-1:0] cdb_name;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic                      disp_valid;
  logic [NAME_W-1:0]         disp_name;
  logic [TAG_W-1:0]          disp_tag;
  logic                      flush;
  logic [NUM_RD*NAME_W-1:0]  rd_name;
  logic [NUM_RD*DATA_W-1:0]  rd_data;
  logic [NUM_RD*TAG_W-1:0]   rd_tag;
  logic [NAME_W:0]           busy_cnt;

  modport master (
    output cdb_valid, cdb_name, cdb_tag, cdb_data,
    output disp_valid, disp_name, disp_tag, flush, rd_name,
    input  rd_data, rd_tag, busy_cnt
  );

  modport slave (
    input  cdb_valid, cdb_name, cdb_tag, cdb_data,
    input  disp_valid, disp_name, disp_tag, flush, rd_name,
    output rd_data, rd_tag, busy_cnt
  );
endinterface

// File: rtl/rename_regfile_read_port.sv
// One combinational source-operand read: register mux, x0 forced to zero/free.
// Configuration macro: RF_CDB_BYPASS_EN adds a same-cycle forward from effective CDB channels.
module rf_read_port
  import rename_regfile_pkg::*;
#(
  parameter int NREG    = RF_NREG,
  parameter int DATA_W  = RF_DATA_W,
  parameter int TAG_W   = RF_TAG_W,
`ifdef RF_CDB_BYPASS_EN
  parameter int NUM_CDB = RF_NUM_CDB,
`endif
  localparam int NAME_W = clog2(NREG)
) (
  input  logic [NAME_W-1:0] rd_name,
  input  logic [DATA_W-1:0] data_q [NREG],
  input  logic [TAG_W-1:0]  tag_q  [NREG],
`ifdef RF_CDB_BYPASS_EN
  input  logic [NUM_CDB-1:0] cdb_eff,
  input  logic [NAME_W-1:0]  cdb_name [NUM_CDB],
  input  logic [DATA_W-1:0]  cdb_data [NUM_CDB],
`endif
  output logic [DATA_W-1:0] rd_data,
  output logic [TAG_W-1:0]  rd_tag
);
  always_comb begin
    rd_data = data_q[rd_name];
    rd_tag  = tag_q[rd_name];
    if (rd_name == '0) begin
      rd_data = '0;
      rd_tag  = TAG_W'(TAG_FREE);
    end
`ifdef RF_CDB_BYPASS_EN
    // Descending scan so the lowest channel wins, matching the write priority.
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (cdb_eff[k] && (cdb_name[k] == rd_name)) begin
        rd_data = cdb_data[k];
        rd_tag  = TAG_W'(TAG_FREE);
      end
    end
`endif
  end
endmodule

// File: rtl/rename_regfile.sv
// Tomasulo architectural register file: data + rename tag per register, CDB resolve,
// single dispatch rename and mispredict flush. Configuration macro: RF_CDB_BYPASS_EN.
module rename_regfile
  import rename_regfile_pkg::*;
#(
  parameter int NREG    = RF_NREG,
  parameter int DATA_W  = RF_DATA_W,
  parameter int TAG_W   = RF_TAG_W,
  parameter int NUM_RD  = RF_NUM_RD,
  parameter int NUM_CDB = RF_NUM_CDB
) (
  input logic             clk,
  input logic             rst,
  rename_regfile_if.slave bus
);
  localparam int NAME_W = clog2(NREG);
  localparam int CNT_W  = NAME_W + 1;
  localparam logic [TAG_W-1:0] FREE = TAG_W'(TAG_FREE);

  logic [DATA_W-1:0] data_q [NREG];
  logic [DATA_W-1:0] data_d [NREG];
  logic [TAG_W-1:0]  tag_q  [NREG];
  logic [TAG_W-1:0]  tag_d  [NREG];
  logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;

  logic [NAME_W-1:0]  c_name [NUM_CDB];
  logic [TAG_W-1:0]   c_tag  [NUM_CDB];
  logic [DATA_W-1:0]  c_data [NUM_CDB];
  logic [NUM_CDB-1:0] c_eff;
  logic               dup_eff;

  // A broadcast only counts when its tag still owns the register; stale ones vanish.
  always_comb begin
    dup_eff = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) begin
      c_name[k] = bus.cdb_name[k*NAME_W +: NAME_W];
      c_tag[k]  = bus.cdb_tag[k*TAG_W +: TAG_W];
      c_data[k] = bus.cdb_data[k*DATA_W +: DATA_W];
      c_eff[k]  = bus.cdb_valid[k] && (c_name[k] != '0) && (c_tag[k] == tag_q[c_name[k]]);
    end
    for (int i = 0; i < NUM_CDB; i++)
      for (int j = i + 1; j < NUM_CDB; j++)
        if (c_eff[i] && c_eff[j] && (c_name[i] == c_name[j])) dup_eff = 1'b1;
  end

  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (c_eff[k]) begin
        data_d[c_name[k]] = c_data[k];
        tag_d[c_name[k]]  = FREE;
      end
    end
    // Flush drops the concurrent dispatch; otherwise the new rename beats the CDB clear.
    if (bus.flush) begin
      for (int i = 0; i < NREG; i++) tag_d[i] = FREE;
    end else if (bus.disp_valid && (bus.disp_name != '0)) begin
      tag_d[bus.disp_name] = bus.disp_tag;
    end
    busy_cnt_d = '0;
    for (int i = 1; i < NREG; i++)
      if (tag_d[i] != FREE) busy_cnt_d = busy_cnt_d + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= FREE;
      end
      busy_cnt_q <= '0;
    end else begin
      assert (!dup_eff);
      data_q     <= data_d;
      tag_q      <= tag_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign bus.busy_cnt = busy_cnt_q;

  logic [DATA_W-1:0] rd_data_w [NUM_RD];
  logic [TAG_W-1:0]  rd_tag_w  [NUM_RD];

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    rf_read_port #(
      .NREG    (NREG),
      .DATA_W  (DATA_W),
`ifdef RF_CDB_BYPASS_EN
      .NUM_CDB (NUM_CDB),
`endif
      .TAG_W   (TAG_W)
    ) u_rd (
      .rd_name  (bus.rd_name[j*NAME_W +: NAME_W]),
      .data_q   (data_q),
      .tag_q    (tag_q),
`ifdef RF_CDB_BYPASS_EN
      .cdb_eff  (c_eff),
      .cdb_name (c_name),
      .cdb_data (c_data),
`endif
      .rd_data  (rd_data_w[j]),
      .rd_tag   (rd_tag_w[j])
    );
  end

  always_comb begin
    for (int j = 0; j < NUM_RD; j++) begin
      bus.rd_data[j*DATA_W +: DATA_W] = rd_data_w[j];
      bus.rd_tag[j*TAG_W +: TAG_W]    = rd_tag_w[j];
    end
  end
endmodule

// File: tb/tb_rename_regfile.sv
// Scoreboard bench for rename_regfile: expected reads queued with stimulus, drained via read ports.
module tb_rename_regfile;
  import rename_regfile_pkg::*;

  typedef struct {
    int          port;
    logic [4:0]  name;
    logic [31:0] data;
    logic [3:0]  tag;
    string       nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  rename_regfile_if bus ();

  rename_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    bus.cdb_valid  = '0;
    bus.disp_valid = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic disp(input logic [4:0] n, input logic [3:0] t);
    bus.disp_valid = 1'b1;
    bus.disp_name  = n;
    bus.disp_tag   = t;
  endtask

  task automatic cdb(input int k, input cdb_bus_t c);
    bus.cdb_valid[k]         = c.valid;
    bus.cdb_name[k*5 +: 5]   = c.name;
    bus.cdb_tag[k*4 +: 4]    = c.tag;
    bus.cdb_data[k*32 +: 32] = c.data;
  endtask

  task automatic peek(input int p, input logic [4:0] n,
                      output logic [31:0] d, output logic [3:0] t);
    bus.rd_name[p*5 +: 5] = n;
    #1;
    d = bus.rd_data[p*32 +: 32];
    t = bus.rd_tag[p*4 +: 4];
  endtask

  task automatic test_reset();
    exp_t e; logic [31:0] d; logic [3:0] t;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1) disp(5'($urandom_range(0, 31)), 4'($urandom_range(1, 15)));
      cdb(0, '{valid: 1'b1, name: 5'($urandom_range(0, 31)), tag: 4'($urandom_range(0, 15)),
               data: $urandom});
      tick();
    end
    rst = 1'b0;
    tick();
    tick();
    foreach (sb[i]) ;
    for (int p = 0; p < 2; p++) begin
      sb.push_back('{p, 5'd1, 32'h0, 4'h0, "reset_x1"});
      sb.push_back('{p, 5'd5, 32'h0, 4'h0, "reset_x5"});
      sb.push_back('{p, 5'd31, 32'h0, 4'h0, "reset_x31"});
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      peek(e.port, e.name, d, t);
      total++;
      if (d !== e.data || t !== e.tag) begin
        bad++;
        $display("FAIL %s p%0d: data=%h tag=%h, required data=%h tag=%h", e.nm, e.port, d, t, e.data, e.tag);
      end
    end
    total++;
    if (bus.busy_cnt !== 6'd0) begin
      bad++;
      $display("FAIL reset_busy: busy_cnt=%0d, required 0", bus.busy_cnt);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_rename_resolve();
    exp_t e; logic [31:0] d; logic [3:0] t;
    disp(5'd5, 4'd3);
    tick();
    sb.push_back('{0, 5'd5, 32'h0, 4'd3, "rename_x5"});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      peek(e.port, e.name, d, t);
      total++;
      if (d !== e.data || t !== e.tag) begin
        bad++;
        $display("FAIL %s: data=%h tag=%h, required data=%h tag=%h", e.nm, d, t, e.data, e.tag);
      end
    end
    total++;
    if (bus.busy_cnt !== 6'd1) begin
      bad++;
      $display("FAIL rename_busy: busy_cnt=%0d, required 1", bus.busy_cnt);
    end
    cdb(0, '{valid: 1'b1, name: 5'd5, tag: 4'd3, data: 32'hDEAD});
    tick();
    sb.push_back('{0, 5'd5, 32'hDEAD, 4'd0, "resolve_x5"});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      peek(e.port, e.name, d, t);
      total++;
      if (d !== e.data || t !== e.tag) begin
        bad++;
        $display("FAIL %s: data=%h tag=%h, required data=%h tag=%h", e.nm, d, t, e.data, e.tag);
      end
    end
    total++;
    if (bus.busy_cnt !== 6'd0) begin
      bad++;
      $display("FAIL resolve_busy: busy_cnt=%0d, required 0", bus.busy_cnt);
    end
  endtask

  task automatic test_stale();
    exp_t e; logic [31:0] d; logic [3:0] t;
    disp(5'd5, 4'd3);
    tick();
    disp(5'd5, 4'd7);
    tick();
    cdb(1, '{valid: 1'b1, name: 5'd5, tag: 4'd3, data: 32'h1});
    tick();
    sb.push_back('{0, 5'd5, 32'hDEAD, 4'd7, "stale_x5"});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      peek(e.port, e.name, d, t);
      total++;
      if (d !== e.data || t !== e.tag) begin
        bad++;
        $display("FAIL %s: data=%h tag=%h, required data=%h tag=%h", e.nm, d, t, e.data, e.tag);
      end
    end
    total++;
    if (bus.busy_cnt !== 6'd1) begin
      bad++;
      $display("FAIL stale_busy: busy_cnt=%0d, required 1", bus.busy_cnt);
    end
  endtask

  task automatic test_bypass();
    exp_t e; logic [31:0] d; logic [3:0] t;
    cdb(1, '{valid: 1'b1, name: 5'd5, tag: 4'd7, data: 32'hAB});
`ifdef RF_CDB_BYPASS_EN
    sb.push_back('{0, 5'd5, 32'hAB, 4'd0, "bypass_same_cycle"});
`else
    sb.push_back('{0, 5'd5, 32'hDEAD, 4'd7, "nobypass_same_cycle"});
`endif
    while (sb.size() > 0) begin
      e = sb.pop_front();
      peek(e.port, e.name, d, t);
      total++;
      if (d !== e.data || t !== e.tag) begin
        bad++;
        $display("FAIL %s: data=%h tag=%h, required data=%h tag=%h", e.nm, d, t, e.data, e.tag);
      end
    end
    tick();
    sb.push_back('{1, 5'd5, 32'hAB, 4'd0, "bypass_next_cycle"});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      peek(e.port, e.name, d, t);
      total++;
      if (d !== e.data || t !== e.tag) begin
        bad++;
        $display("FAIL %s: data=%h tag=%h, required data=%h tag=%h", e.nm, d, t, e.data, e.tag);
      end
    end
    total++;
    if (bus.busy_cnt !== 6'd0) begin
      bad++;
      $display("FAIL bypass_busy: busy_cnt=%0d, required 0", bus.busy_cnt);
    end
  endtask

  task automatic test_simultaneous();
    exp_t e; logic [31:0] d; logic [3:0] t;
    disp(5'd5, 4'd7);
    tick();
    cdb(0, '{valid: 1'b1, name: 5'd5, tag: 4'd7, data: 32'h1234});
    disp(5'd5, 4'd9);
    tick();
    sb.push_back('{0, 5'd5, 32'h1234, 4'd9, "simul_x5"});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      peek(e.port, e.name, d, t);
      total++;
      if (d !== e.data || t !== e.tag) begin
        bad++;
        $display("FAIL %s: data=%h tag=%h, required data=%h tag=%h", e.nm, d, t, e.data, e.tag);
      end
    end
    total++;
    if (bus.busy_cnt !== 6'd1) begin
      bad++;
      $display("FAIL simul_busy: busy_cnt=%0d, required 1", bus.busy_cnt);
    end
  endtask

  task automatic test_x0();
    exp_t e; logic [31:0] d; logic [3:0] t;
    disp(5'd0, 4'd5);
    cdb(0, '{valid: 1'b1, name: 5'd0, tag: 4'd0, data: 32'hFF});
    tick();
    sb.push_back('{0, 5'd0, 32'h0, 4'd0, "x0_p0"});
    sb.push_back('{1, 5'd0, 32'h0, 4'd0, "x0_p1"});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      peek(e.port, e.name, d, t);
      total++;
      if (d !== e.data || t !== e.tag) begin
        bad++;
        $display("FAIL %s: data=%h tag=%h, required data=%h tag=%h", e.nm, d, t, e.data, e.tag);
      end
    end
    total++;
    if (bus.busy_cnt !== 6'd1) begin
      bad++;
      $display("FAIL x0_busy: busy_cnt=%0d, required 1", bus.busy_cnt);
    end
  endtask

  task automatic test_flush();
    exp_t e; logic [31:0] d; logic [3:0] t;
    disp(5'd1, 4'd1); tick();
    disp(5'd2, 4'd4); tick();
    disp(5'd3, 4'd6); tick();
    total++;
    if (bus.busy_cnt !== 6'd4) begin
      bad++;
      $display("FAIL flush_prebusy: busy_cnt=%0d, required 4", bus.busy_cnt);
    end
    bus.flush = 1'b1;
    disp(5'd6, 4'd2);
    cdb(0, '{valid: 1'b1, name: 5'd1, tag: 4'd1, data: 32'h55});
    tick();
    sb.push_back('{0, 5'd1, 32'h55, 4'd0, "flush_x1"});
    sb.push_back('{1, 5'd2, 32'h0, 4'd0, "flush_x2"});
    sb.push_back('{0, 5'd3, 32'h0, 4'd0, "flush_x3"});
    sb.push_back('{1, 5'd5, 32'h1234, 4'd0, "flush_x5"});
    sb.push_back('{0, 5'd6, 32'h0, 4'd0, "flush_x6"});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      peek(e.port, e.name, d, t);
      total++;
      if (d !== e.data || t !== e.tag) begin
        bad++;
        $display("FAIL %s: data=%h tag=%h, required data=%h tag=%h", e.nm, d, t, e.data, e.tag);
      end
    end
    total++;
    if (bus.busy_cnt !== 6'd0) begin
      bad++;
      $display("FAIL flush_busy: busy_cnt=%0d, required 0", bus.busy_cnt);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; logic [31:0] d; logic [3:0] t;
    disp(5'd10, 4'd1); tick();
    disp(5'd11, 4'd2); tick();
    cdb(0, '{valid: 1'b1, name: 5'd10, tag: 4'd1, data: 32'hA0A0});
    cdb(1, '{valid: 1'b1, name: 5'd11, tag: 4'd2, data: 32'hB1B1});
    disp(5'd12, 4'd3);
    sb.push_back('{0, 5'd12, 32'h0, 4'd0, "b2b_no_same_cycle_rename"});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      peek(e.port, e.name, d, t);
      total++;
      if (d !== e.data || t !== e.tag) begin
        bad++;
        $display("FAIL %s: data=%h tag=%h, required data=%h tag=%h", e.nm, d, t, e.data, e.tag);
      end
    end
    tick();
    sb.push_back('{0, 5'd10, 32'hA0A0, 4'd0, "b2b_x10"});
    sb.push_back('{1, 5'd11, 32'hB1B1, 4'd0, "b2b_x11"});
    sb.push_back('{1, 5'd12, 32'h0, 4'd3, "b2b_x12"});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      peek(e.port, e.name, d, t);
      total++;
      if (d !== e.data || t !== e.tag) begin
        bad++;
        $display("FAIL %s: data=%h tag=%h, required data=%h tag=%h", e.nm, d, t, e.data, e.tag);
      end
    end
    total++;
    if (bus.busy_cnt !== 6'd1) begin
      bad++;
      $display("FAIL b2b_busy: busy_cnt=%0d, required 1", bus.busy_cnt);
    end
  endtask

  initial begin
    idle();
    bus.disp_name = '0;
    bus.disp_tag  = '0;
    bus.cdb_name  = '0;
    bus.cdb_tag   = '0;
    bus.cdb_data  = '0;
    bus.rd_name   = '0;
    tick();
    tick();
    test_reset();
    test_rename_resolve();
    test_stale();
    test_bypass();
    test_simultaneous();
    test_x0();
    test_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
- Parametrised Tomasulo architectural register file holding a data value and a rename tag per register.
- Sits between decoder/dispatcher and the common data bus (CDB). Gives N combinational source-operand reads, takes M CDB result channels per cycle, and one dispatch rename per cycle.
- Adds a global flush for branch-mispredict recovery.
- Register 0 is hardwired to zero and is never renamed.

Parameters:
- NREG, 32, number of architectural registers (power of two); NAME_W = clog2(NREG)
- DATA_W, 32, register data width
- TAG_W, 4, rename tag width; tag value TAG_FREE (all zeros) means "value is valid in file"
- NUM_RD, 2, number of combinational read ports
- NUM_CDB, 2, number of CDB broadcast channels

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge)
- cdb_valid  in  NUM_CDB  per-channel broadcast valid
- cdb_name  in  NUM_CDB*NAME_W  destination register per channel
- cdb_tag  in  NUM_CDB*TAG_W  producing tag per channel
- cdb_data  in  NUM_CDB*DATA_W  result per channel
- disp_valid  in  1  dispatch renames a destination this cycle
- disp_name  in  NAME_W  destination register being renamed
- disp_tag  in  TAG_W  new tag, never TAG_FREE
- flush  in  1  mispredict: free every tag
- rd_name  in  NUM_RD*NAME_W  source register per read port
- rd_data  out  NUM_RD*DATA_W  register data
- rd_tag  out  NUM_RD*TAG_W  pending tag, or TAG_FREE
- busy_cnt  out  NAME_W+1  registered count of registers holding a non-free tag

Behaviour:
- Reset (rst==0 at edge): every data = 0, every tag = TAG_FREE, busy_cnt = 0. Reads are combinational from state, so they return 0/TAG_FREE while reset is held. Reset overrides flush, dispatch and CDB in the same cycle.
- CDB channel k is effective when all three hold: cdb_valid[k], cdb_name[k] != 0, and cdb_tag[k] == tag[cdb_name[k]]. Stale broadcasts (tag mismatch) are ignored entirely; data is not written.
- Effective channel: data[name] <= cdb_data at the next edge. tag[name] <= TAG_FREE, unless dispatch renames the same name this cycle; then the dispatch tag wins.
- Dispatch: when disp_valid and disp_name != 0, tag[disp_name] <= disp_tag. Data is untouched. disp_name == 0 is ignored.
- Two effective channels naming the same register cannot occur, because tags are unique. Implementation asserts this in simulation; on violation the lowest k wins.
- Flush: all tags <= TAG_FREE next edge and busy_cnt <= 0. A concurrent dispatch is discarded. Effective CDB data writes in the same cycle are still performed.
- Reads: rd_data[j]/rd_tag[j] = data/tag[rd_name[j]] from current state (0-cycle latency). rd_name == 0 returns 0/TAG_FREE.
- A read never observes a same-cycle dispatch. Source operands of an instruction renaming its own source (e.g. x1 <- x1+x2) see the old tag.
- busy_cnt: next = current + (dispatch to a free, nonzero register) − (number of effective CDB clears not overwritten by dispatch). It is recomputed from the next-state tag vector each cycle, never incrementally drifting.

Optional Feature:
- Macro RF_CDB_BYPASS_EN.
- Defined: if an effective CDB channel this cycle matches read port j's name, rd_data[j] = that channel's cdb_data and rd_tag[j] = TAG_FREE, same cycle.
- Undefined: reads reflect register state only. The forwarded value appears one cycle later, and the consumer must snoop the CDB itself.

Decomposition:
- Shared package: TAG_FREE, NAME_W/TAG_W/DATA_W derivation, a cdb_bus_t packed struct (valid, name, tag, data), and a clog2 helper.
- One sub-module, rf_read_port: a single read mux plus the optional bypass compare, instantiated NUM_RD times by generate.

Test Plan:
- Reset: hold rst=0 two cycles after random activity -> all rd_data=0, rd_tag=0, busy_cnt=0.
- Rename then resolve: dispatch x5 tag 3; next cycle rd x5 -> tag 3. CDB{x5, tag 3, 0xDEAD} -> next cycle data 0xDEAD, tag free, busy_cnt back to 0.
- Stale broadcast: x5 tag 3 then re-dispatch x5 tag 7; CDB{x5, tag 3, 0x1} -> x5 data unchanged, tag stays 7.
- Simultaneous: CDB{x5, tag 7} and dispatch x5 tag 9 in the same cycle -> data updated, tag 9, busy_cnt unchanged.
- Flush: four registers busy, flush with concurrent dispatch x6 tag 2 -> all tags free, x6 not renamed, busy_cnt=0.
- x0 and bypass: dispatch x0 / CDB to x0 -> reads 0/free. With RF_CDB_BYPASS_EN, CDB{x5, tag 7, 0xAB} reads 0xAB/free the same cycle; without it, the old data/tag 7 is returned.
